// File: rtl/sccpu_regfile_mp.sv
// Parametrised multi-read-port register file with optional write bypass, optional
// hardwired zero register, sequential sweep-clear engine and saturating write counter.
module sccpu_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wn,
  input  logic [DATA_W-1:0]        d,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] q,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_lost,
  output logic [CNT_W-1:0]         wr_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_START = (ZERO_REG != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_lost_q, wr_lost_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic wr_r0_s;
  logic wr_acc_s;

  // A write to r0 is a non-event when r0 is hardwired: not stored, counted or flagged.
  assign wr_r0_s  = (ZERO_REG != 0) && (wn == ADDR_W'(0));
  assign wr_acc_s = (state_q == ST_IDLE) && we && !wr_r0_s;

  // State register, including the storage array and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      wr_lost_q  <= 1'b0;
      wr_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      wr_lost_q  <= wr_lost_d;
      wr_count_q <= wr_count_d;
      mem_q      <= mem_d;
    end
  end

  // Next-state logic for the sweep-clear sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          ptr_d   = PTR_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        // Terminal pointer value: stop here rather than wrapping back into the array.
        if (ptr_q == PTR_LAST) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Output logic: handshake flags follow the next state so they register in step with it.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    clr_done_d = (state_d == ST_DONE);
  end

  // Datapath next values: array update, write counter and lost-write flag.
  always_comb begin
    mem_d      = mem_q;
    wr_count_d = wr_count_q;
    wr_lost_d  = wr_lost_q;
    if (wr_acc_s) begin
      mem_d[wn] = d;
      if (wr_count_q != {CNT_W{1'b1}}) begin
        wr_count_d = wr_count_q + CNT_W'(1);
      end else begin
        wr_count_d = wr_count_q;
      end
    end else if (state_q == ST_SWEEP) begin
      mem_d[ptr_q] = '0;
    end else begin
      mem_d = mem_q;
    end
    if ((state_q == ST_IDLE) && clr_req) begin
      wr_lost_d = 1'b0;
    end else if ((state_q != ST_IDLE) && we && !wr_r0_s) begin
      wr_lost_d = 1'b1;
    end else begin
      wr_lost_d = wr_lost_q;
    end
  end

  // Combinational read ports; bypass only while idle so a sweep shows real contents.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] q_s;

    assign ra_s = ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      if ((ZERO_REG != 0) && (ra_s == ADDR_W'(0))) begin
        q_s = '0;
      end else if ((BYPASS != 0) && wr_acc_s && (wn == ra_s)) begin
        q_s = d;
      end else begin
        q_s = mem_q[ra_s];
      end
    end

    assign q[g*DATA_W +: DATA_W] = q_s;
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign wr_lost  = wr_lost_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sccpu_regfile_mp.sv
// Directed scoreboard bench: default instance plus a BYPASS=0/ZERO_REG=0/CNT_W=3 instance.
module tb_sccpu_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic        we, we_b;
  logic [4:0]  wn, wn_b;
  logic [31:0] d, d_b;
  logic [9:0]  ra, ra_b;
  logic [63:0] q, q_b;
  logic        clr_req, clr_req_b;
  logic        busy, busy_b, clr_done, clr_done_b, wr_lost, wr_lost_b;
  logic [15:0] wr_count;
  logic [2:0]  wr_count_b;

  int          n_cmp = 0;
  int          n_err = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];
  int          busy_cnt, done_cnt, done_at;

  sccpu_regfile_mp dut (
    .clock(clock), .reset(reset), .we(we), .wn(wn), .d(d), .ra(ra), .q(q),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_lost(wr_lost),
    .wr_count(wr_count)
  );

  sccpu_regfile_mp #(.BYPASS(0), .ZERO_REG(0), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .we(we_b), .wn(wn_b), .d(d_b), .ra(ra_b), .q(q_b),
    .clr_req(clr_req_b), .busy(busy_b), .clr_done(clr_done_b), .wr_lost(wr_lost_b),
    .wr_count(wr_count_b)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic chk(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; wn = '0; d = '0; ra = '0; clr_req = 1'b0;
    we_b = 1'b0; wn_b = '0; d_b = '0; ra_b = '0; clr_req_b = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    push("rst_busy", 64'd0);     chk({63'd0, busy});
    push("rst_done", 64'd0);     chk({63'd0, clr_done});
    push("rst_lost", 64'd0);     chk({63'd0, wr_lost});
    push("rst_count", 64'd0);    chk({48'd0, wr_count});
    reset = 1'b1;

    // Basic write then read
    we = 1'b1; wn = 5'd5; d = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; ra = {5'd0, 5'd5};
    #1;
    push("rd_r5", 64'hDEAD_BEEF); chk({32'd0, q[31:0]});
    push("rd_r0", 64'd0);         chk({32'd0, q[63:32]});
    push("count_1", 64'd1);       chk({48'd0, wr_count});

    // Same-cycle forwarding vs. no forwarding
    we = 1'b1; wn = 5'd7; d = 32'h1234_5678; ra = {5'd0, 5'd7};
    we_b = 1'b1; wn_b = 5'd7; d_b = 32'h1234_5678; ra_b = {5'd0, 5'd7};
    #1;
    push("bypass_on", 64'h1234_5678); chk({32'd0, q[31:0]});
    push("bypass_off_old", 64'd0);    chk({32'd0, q_b[31:0]});
    tick();
    we = 1'b0; we_b = 1'b0;
    #1;
    push("bypass_off_new", 64'h1234_5678); chk({32'd0, q_b[31:0]});
    push("count_b_1", 64'd1);              chk({61'd0, wr_count_b});

    // Hardwired zero register
    we = 1'b1; wn = 5'd0; d = 32'hFFFF_FFFF; ra = {5'd0, 5'd0};
    #1;
    push("r0_same_cycle", 64'd0); chk({32'd0, q[31:0]});
    tick();
    we = 1'b0;
    #1;
    push("r0_after", 64'd0);  chk({32'd0, q[31:0]});
    push("count_2", 64'd2);   chk({48'd0, wr_count});
    push("r0_lost", 64'd0);   chk({63'd0, wr_lost});

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wn = 5'(i); d = 32'(i);
      tick();
    end
    we = 1'b0; ra = {5'd1, 5'd31};
    #1;
    push("fill_r31", 64'd31); chk({32'd0, q[31:0]});
    push("fill_r1", 64'd1);   chk({32'd0, q[63:32]});
    push("count_33", 64'd33); chk({48'd0, wr_count});

    // Sweep clear with a write dropped mid-sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) ra = {5'd2, 5'd10};
      if (k == 10) begin
        we = 1'b1; wn = 5'd20; d = 32'hAAAA_AAAA; ra = {5'd1, 5'd20};
      end else begin
        we = 1'b0;
      end
      #1;
      if (k == 5) begin
        push("mid_sweep_r10", 64'd10); chk({32'd0, q[31:0]});
        push("mid_sweep_r2", 64'd0);   chk({32'd0, q[63:32]});
      end
      if (k == 10) begin
        push("no_bypass_busy", 64'd20); chk({32'd0, q[31:0]});
      end
      if (busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_at = k;
      end
      tick();
    end
    push("sweep_busy_cycles", 64'd32); chk(64'(busy_cnt));
    push("sweep_done_at", 64'd32);     chk(64'(done_at));
    push("sweep_done_pulses", 64'd1);  chk(64'(done_cnt));
    push("sweep_lost", 64'd1);         chk({63'd0, wr_lost});
    push("sweep_count", 64'd33);       chk({48'd0, wr_count});
    for (int i = 0; i < 32; i += 2) begin
      ra = {5'(i + 1), 5'(i)};
      #1;
      push("cleared", 64'd0); chk(q);
    end

    // Next accepted clr_req clears the lost flag
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    push("lost_cleared", 64'd0); chk({63'd0, wr_lost});
    push("sweep2_busy", 64'd1);  chk({63'd0, busy});
    for (int k = 0; k < 40 && busy; k++) tick();
    push("sweep2_end", 64'd0);   chk({63'd0, busy});

    // Asynchronous reset in the middle of a sweep
    we = 1'b1; wn = 5'd20; d = 32'd55;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick(); tick();
    ra = {5'd31, 5'd20};
    #1;
    push("pre_rst_r20", 64'd55);    chk({32'd0, q[31:0]});
    push("pre_rst_count", 64'd34);  chk({48'd0, wr_count});
    push("pre_rst_busy", 64'd1);    chk({63'd0, busy});
    reset = 1'b0;
    #1;
    push("arst_busy", 64'd0);  chk({63'd0, busy});
    push("arst_done", 64'd0);  chk({63'd0, clr_done});
    push("arst_count", 64'd0); chk({48'd0, wr_count});
    push("arst_regs", 64'd0);  chk(q);
    push("arst_count_b", 64'd0); chk({61'd0, wr_count_b});
    tick();
    reset = 1'b1;
    tick();
    push("post_rst_idle", 64'd0); chk({63'd0, busy});

    // Counter saturation on the 3-bit instance
    for (int i = 1; i <= 9; i++) begin
      we_b = 1'b1; wn_b = 5'(i); d_b = 32'(i * 3);
      tick();
      we_b = 1'b0;
      #1;
      push("sat_count", 64'(i < 7 ? i : 7)); chk({61'd0, wr_count_b});
    end
    ra_b = {5'd9, 5'd4};
    #1;
    push("b_r4", 64'd12); chk({32'd0, q_b[31:0]});
    push("b_r9", 64'd27); chk({32'd0, q_b[63:32]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
